// File: rtl/buffer_pkg.sv
// Shared defaults and width helpers for the stream buffer FIFO family.
// The top and its storage sub-module import this package.
package buffer_pkg;

    localparam int BUF_DEFAULT_WIDTH = 16;
    localparam int BUF_DEFAULT_DEPTH = 4;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/buffer_mem.sv
// Register-array storage for the stream buffer: one synchronous write port, one asynchronous read port.
// The array is deliberately left unreset; validity is tracked by the occupancy count in the top level.
module buffer_mem
    import buffer_pkg::*;
#(
    parameter int WIDTH = BUF_DEFAULT_WIDTH,
    parameter int DEPTH = BUF_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);

    logic [WIDTH-1:0] memArray [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            memArray[wrAddr] <= wrData;
        end
    end

    // Asynchronous read gives first-word fall-through without an output register.
    assign rdData = memArray[rdAddr];

endmodule

// File: rtl/stream_buffer_fifo.sv
// Parametrised first-word-fall-through FIFO with valid/ready handshakes on both sides,
// occupancy output and an almost-full warning. Full/empty are decided purely by the count.
module stream_buffer_fifo
    import buffer_pkg::*;
#(
    parameter int WIDTH    = BUF_DEFAULT_WIDTH,
    parameter int DEPTH    = BUF_DEFAULT_DEPTH,
    parameter int AF_LEVEL = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : gBadParams
        $fatal(1, "stream_buffer_fifo: DEPTH must be a power of two >= 2 and AF_LEVEL within 1..DEPTH");
    end

    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [CW-1:0]    countReg;
    logic [WIDTH-1:0] headData;
    logic             push;
    logic             pop;

    assign in_ready    = (countReg != CW'(DEPTH));
    assign out_valid   = (countReg != '0);
    assign almost_full = (countReg >= CW'(AF_LEVEL));
    assign count       = countReg;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Flush wins over any transfer in the same cycle; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            countReg <= '0;
        end else if (flush) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            countReg <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({push, pop})
                2'b10:   countReg <= countReg + CW'(1);
                2'b01:   countReg <= countReg - CW'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) uMem (
        .clk    (clk),
        .wrEn   (push & ~flush),
        .wrAddr (wrPtr),
        .wrData (in_data),
        .rdAddr (rdPtr),
        .rdData (headData)
    );

    assign out_data = out_valid ? headData : '0;

endmodule

// File: tb/tb_stream_buffer_fifo.sv
// Self-checking bench for stream_buffer_fifo: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the FIFO.
module tb_stream_buffer_fifo;
    import buffer_pkg::*;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = 3;
    localparam int CW       = cnt_width(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             almost_full;

    int vecCount  = 0;
    int missCount = 0;
    logic [WIDTH-1:0] refQ [$];

    stream_buffer_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow directly from what the model queue holds.
    task automatic checkOutputs(input string ctx);
        int n;
        logic [WIDTH-1:0] head;
        n = refQ.size();
        head = (n > 0) ? refQ[0] : '0;
        checkVal({ctx, ".count"},       32'(count),       32'(n));
        checkVal({ctx, ".out_valid"},   32'(out_valid),   32'(n != 0));
        checkVal({ctx, ".in_ready"},    32'(in_ready),    32'(n != DEPTH));
        checkVal({ctx, ".almost_full"}, 32'(almost_full), 32'(n >= AF_LEVEL));
        checkVal({ctx, ".out_data"},    32'(out_data),    32'(head));
    endtask

    // One clock of traffic: drive, check current state at negedge, update model at posedge.
    task automatic step(input string ctx, input logic v, input logic [WIDTH-1:0] d,
                        input logic r, input logic f);
        bit doPush;
        bit doPop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(negedge clk);
        checkOutputs(ctx);
        doPush = v && (refQ.size() < DEPTH);
        doPop  = r && (refQ.size() > 0);
        @(posedge clk);
        if (f) begin
            refQ.delete();
        end else begin
            if (doPop) void'(refQ.pop_front());
            if (doPush) refQ.push_back(d);
        end
        $display("%s: in_valid=%0b data=%h out_ready=%0b flush=%0b push=%0b pop=%0b occ=%0d",
                 ctx, v, d, r, f, doPush && !f, doPop && !f, refQ.size());
        #1;
    endtask

    initial begin
        int pushPct [3] = '{80, 30, 55};
        int popPct  [3] = '{30, 80, 55};

        // Reset and idle
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutputs("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("idle", 1'b0, '0, 1'b0, 1'b0);

        // Fill, refused fifth push, drain
        step("fill1", 1'b1, 16'h1111, 1'b0, 1'b0);
        step("fill2", 1'b1, 16'h2222, 1'b0, 1'b0);
        step("fill3", 1'b1, 16'h3333, 1'b0, 1'b0);
        step("fill4", 1'b1, 16'h4444, 1'b0, 1'b0);
        step("fill5_refused", 1'b1, 16'h5555, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
        step("drained", 1'b0, '0, 1'b0, 1'b0);

        // Simultaneous push/pop at count 2, crossing pointer wrap
        step("pre_a", 1'b1, 16'h0A01, 1'b0, 1'b0);
        step("pre_b", 1'b1, 16'h0A02, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("simul", 1'b1, 16'h0B00 + 16'(i), 1'b1, 1'b0);

        // Full plus pop: only the pop happens, push accepted the cycle after
        step("top_up1", 1'b1, 16'h0C01, 1'b0, 1'b0);
        step("top_up2", 1'b1, 16'h0C02, 1'b0, 1'b0);
        step("full_pop", 1'b1, 16'h0C03, 1'b1, 1'b0);
        step("after_full_pop", 1'b1, 16'h0C03, 1'b0, 1'b0);
        step("full_again", 1'b0, '0, 1'b0, 1'b0);

        // Flush priority over push and pop at count 3
        step("pre_flush_pop", 1'b0, '0, 1'b1, 1'b0);
        step("flush", 1'b1, 16'hAAAA, 1'b1, 1'b1);
        step("post_flush_push", 1'b1, 16'hBBBB, 1'b0, 1'b0);
        step("post_flush_head", 1'b0, '0, 1'b0, 1'b0);
        step("post_flush_pop", 1'b0, '0, 1'b1, 1'b0);

        // Async reset between edges at count 2
        step("ar_a", 1'b1, 16'h0D01, 1'b0, 1'b0);
        step("ar_b", 1'b1, 16'h0D02, 1'b0, 1'b0);
        step("ar_hold", 1'b0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        refQ.delete();
        checkOutputs("async_rst");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("ar_push", 1'b1, 16'h1234, 1'b0, 1'b0);
        step("ar_head", 1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic in three bias phases
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 150; i++) begin
                logic v;
                logic r;
                logic f;
                v = ($urandom_range(99, 0) < 32'(pushPct[p]));
                r = ($urandom_range(99, 0) < 32'(popPct[p]));
                f = ($urandom_range(63, 0) == 0);
                step("rand", v, WIDTH'($urandom), r, f);
            end
        end
        step("final", 1'b0, '0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
